// File: rtl/sd_session_ctrl.sv
// ---------------------------------------------------------------------------
// sd_session_ctrl
//
// Top-level sequencer for one encrypt/decrypt pass over the SD card. It
// debounces the user start button, pulses the SD protocol block through a
// local reset and a start strobe, then supervises the block's success/fail
// flags. A failed attempt is retried (local reset + start again) up to
// MAX_RETRIES times before the session is declared failed.
//
// Optional build macro:
//   SESSION_WATCHDOG_EN - adds a 32-bit per-attempt timeout. An attempt that
//                         stays in WAIT for WATCHDOG_CYCLES cycles counts as
//                         a failure. Without the macro, WAIT exits only on the
//                         SD block flags.
//
// Ports:
//   iclk        system clock (36 MHz)
//   irst        synchronous active-high reset
//   ibutton     raw asynchronous start button, active-high
//   osd_rst     local reset to the SD block, high for RST_CYCLES cycles
//   osd_start   one-cycle start strobe to the SD block
//   isd_success SD block success flag (level)
//   isd_fail    SD block fail flag (level)
//   obusy       session in progress
//   odone       last session succeeded (held until the next request)
//   oerror      last session failed after all retries (held)
//   oretries    retries consumed in the current/last session
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module sd_session_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 360000,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned RST_CYCLES      = 4,
    parameter int unsigned WATCHDOG_CYCLES = 1080000000
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       ibutton,
    output logic       osd_rst,
    output logic       osd_start,
    input  logic       isd_success,
    input  logic       isd_fail,
    output logic       obusy,
    output logic       odone,
    output logic       oerror,
    output logic [3:0] oretries
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);
    localparam logic [1:0]      BLANK_LEN = 2'd2;

    if (DEBOUNCE_CYCLES < 2 || MAX_RETRIES > 15 || RST_CYCLES < 1 || WATCHDOG_CYCLES < 2)
    begin : g_param_check
        $error("sd_session_ctrl: parameter out of range");
    end

    // -----------------------------------------------------------------------
    // Button path: 2-flop synchroniser, run-length stability counter.
    // -----------------------------------------------------------------------
    logic            btn_meta;
    logic            btn_sync;
    logic            btn_last;
    logic [DB_W-1:0] run_cnt;
    logic [DB_W-1:0] run_nxt;
    logic            db_accept;
    logic            db_level;
    logic            db_valid;
    logic            btn_req;

    // run_cnt holds (length of the current run of equal samples) - 1,
    // saturating once the run is long enough to be accepted.
    always_comb begin
        run_nxt = '0;
        if (btn_sync == btn_last) begin
            run_nxt = (run_cnt == DB_LAST) ? run_cnt : run_cnt + DB_W'(1);
        end
        db_accept = (run_nxt == DB_LAST);
    end

    // db_valid stays low until a first level has been accepted after reset, so
    // a button held through reset is taken as the baseline rather than a press.
    always_ff @(posedge iclk) begin
        if (irst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_last <= 1'b0;
            run_cnt  <= '0;
            db_level <= 1'b0;
            db_valid <= 1'b0;
            btn_req  <= 1'b0;
        end else begin
            btn_meta <= ibutton;
            btn_sync <= btn_meta;
            btn_last <= btn_sync;
            run_cnt  <= run_nxt;
            btn_req  <= 1'b0;
            if (db_accept) begin
                db_level <= btn_sync;
                db_valid <= 1'b1;
                btn_req  <= db_valid && btn_sync && !db_level;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Session FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_SDRST,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [RC_W-1:0] rst_cnt;
    logic [RC_W-1:0] rst_cnt_d;
    logic [1:0]      blank_cnt;
    logic [1:0]      blank_cnt_d;
    logic [3:0]      retries_d;
    logic            done_d;
    logic            error_d;
    logic            flags_live;
    logic            fail_evt;

`ifdef SESSION_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);
    logic [31:0] wd_cnt;
    logic [31:0] wd_cnt_d;
`endif

    always_comb begin
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        blank_cnt_d = blank_cnt;
        retries_d   = oretries;
        done_d      = odone;
        error_d     = oerror;
        flags_live  = 1'b0;
        fail_evt    = 1'b0;
`ifdef SESSION_WATCHDOG_EN
        wd_cnt_d    = wd_cnt;
`endif

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (btn_req) begin
                    state_d   = S_SDRST;
                    rst_cnt_d = '0;
                    retries_d = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end

            S_SDRST: begin
                if (rst_cnt == RC_LAST) begin
                    state_d = S_START;
                end else begin
                    rst_cnt_d = rst_cnt + RC_W'(1);
                end
            end

            S_START: begin
                state_d     = S_WAIT;
                blank_cnt_d = '0;
`ifdef SESSION_WATCHDOG_EN
                wd_cnt_d    = '0;
`endif
            end

            S_WAIT: begin
                flags_live = (blank_cnt == BLANK_LEN);
                if (!flags_live) begin
                    blank_cnt_d = blank_cnt + 2'd1;
                end
`ifdef SESSION_WATCHDOG_EN
                wd_cnt_d = wd_cnt + 32'd1;
`endif
                // Flags outrank the watchdog; fail outranks success.
                if (flags_live && isd_fail) begin
                    fail_evt = 1'b1;
                end else if (flags_live && isd_success) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
`ifdef SESSION_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    fail_evt = 1'b1;
                end
`endif

                if (fail_evt) begin
                    if (oretries < RETRY_MAX) begin
                        retries_d = oretries + 4'd1;
                        rst_cnt_d = '0;
                        state_d   = S_SDRST;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobe outputs are decoded from the next state so they line up with
    // the registered state rather than trailing it by a cycle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            blank_cnt <= '0;
            osd_rst   <= 1'b0;
            osd_start <= 1'b0;
            obusy     <= 1'b0;
            odone     <= 1'b0;
            oerror    <= 1'b0;
            oretries  <= '0;
`ifdef SESSION_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            state     <= state_d;
            rst_cnt   <= rst_cnt_d;
            blank_cnt <= blank_cnt_d;
            osd_rst   <= (state_d == S_SDRST);
            osd_start <= (state_d == S_START);
            obusy     <= (state_d inside {S_SDRST, S_START, S_WAIT});
            odone     <= done_d;
            oerror    <= error_d;
            oretries  <= retries_d;
`ifdef SESSION_WATCHDOG_EN
            wd_cnt    <= wd_cnt_d;
`endif
        end
    end

endmodule

// File: doc/sd_session_ctrl.md
Name: sd_session_ctrl

Overview:
Top-level sequencer for one encrypt/decrypt pass over the SD card.
- Debounces the user start button and issues the start pulse to the SD protocol block.
- Supervises the SD block's success/fail flags, locally resets and retries the SD block on failure, and optionally enforces a session watchdog.
- Drives user-visible status (busy/done/error, retry count).
- Sits between the board button/LEDs and the SD protocol block, on the 36 MHz system clock.

Parameters:
DEBOUNCE_CYCLES, 360000, cycles the synchronised button level must be stable before it is accepted (10 ms at 36 MHz)
MAX_RETRIES, 3, extra attempts after the first failed attempt (0..15)
RST_CYCLES, 4, length of the local SD reset pulse in cycles (>=1)
WATCHDOG_CYCLES, 1080000000, per-attempt timeout in cycles (30 s); 32-bit counter

Ports:
iclk  input  1  system clock, 36 MHz
irst  input  1  global reset, synchronous, active-high
ibutton  input  1  raw asynchronous start button, active-high
osd_rst  output  1  local reset to SD block, active-high, registered
osd_start  output  1  one-cycle start pulse to SD block, registered
isd_success  input  1  SD block success flag (level)
isd_fail  input  1  SD block fail flag (level)
obusy  output  1  session in progress
odone  output  1  last session succeeded (held)
oerror  output  1  last session failed after all retries (held)
oretries  output  4  retries consumed in the current/last session

Behaviour:
- Single clock iclk; reset is synchronous and active-high on irst. All outputs are registered.
- Reset values: all outputs 0; state IDLE; debounced level 0; counters 0.
- Button path:
  - 2-flop synchroniser feeds a stability counter.
  - Debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - A request is a one-cycle 0->1 edge of the debounced level.
- States: IDLE, SDRST, START, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR:
  - On request, clear oretries, odone and oerror, then go to SDRST.
  - A request in any other state is ignored.
- SDRST:
  - osd_rst = 1 for exactly RST_CYCLES cycles.
  - Next state is START; osd_rst is 0 in START.
- START:
  - osd_start = 1 for exactly one cycle, then WAIT.
- WAIT:
  - The first 2 cycles are a blanking window: flags are ignored.
  - After blanking, sample isd_success and isd_fail each cycle.
  - isd_success alone -> DONE, odone = 1.
  - isd_fail, or isd_success and isd_fail in the same cycle (fail wins), or watchdog expiry (see feature) counts as a failure:
    - If oretries < MAX_RETRIES: oretries increments and the state goes to SDRST.
    - Otherwise -> ERROR, oerror = 1; oretries is held.
- obusy = 1 in SDRST, START and WAIT; 0 otherwise.
- MAX_RETRIES = 0 means a single attempt.
- oretries saturates at MAX_RETRIES and never wraps.
- irst mid-session:
  - Immediate return to IDLE with all outputs 0.
  - A button held through reset produces no request until it is released and pressed again, because the debounced level resets to 0 and must first see stable 0 then stable 1.
- osd_start and osd_rst are never high in the same cycle.

Optional Feature:
SESSION_WATCHDOG_EN
- Defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching WATCHDOG_CYCLES-1 counts as a failure in that cycle.
  - If a flag and expiry coincide, the flag takes priority: success -> DONE, fail -> the normal failure path (one retry consumed).
- Undefined:
  - No counter is instantiated.
  - WAIT exits only on SD block flags; WATCHDOG_CYCLES is unused.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=8, MAX_RETRIES=2, RST_CYCLES=4, WATCHDOG_CYCLES=100.
- Button glitch: 5-cycle high pulse -> no request; osd_rst stays 0; obusy stays 0.
- Clean press, 20 cycles high:
  - osd_rst high 4 cycles, then osd_start high 1 cycle.
  - isd_success asserted 10 cycles later -> odone=1, obusy=0, oretries=0.
- isd_fail on every attempt -> 3 SDRST/START sequences; then oerror=1, oretries=2, odone=0.
- Fail once then succeed -> odone=1, oretries=1. A second press restarts with oretries=0 and odone=0.
- isd_success and isd_fail high in the same cycle after blanking -> treated as fail; oretries increments.
- With SESSION_WATCHDOG_EN, flags held low:
  - Each attempt times out 100 cycles after entering WAIT.
  - oerror=1 after 3 attempts.
  - irst asserted mid-WAIT -> all outputs 0 on the next cycle.
